mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning address and data width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum BUSY cycles allowed before abort; legal range 2..255.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have ports req0, req1  input  1 each  transaction request from port 0 (instruction fetch) and port 1 (data).
REQ-006 The block SHALL have ports addr0, addr1  input  WIDTH each  request address; held stable by the requester from req high until done.
REQ-007 The block SHALL have ports we0, we1  input  1 each  write enable; ports wd0, wd1  input  WIDTH each  write data.
REQ-008 The block SHALL have ports gnt0, gnt1  output  1 each  port currently owns the memory.
REQ-009 The block SHALL have ports done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 The block SHALL have port err  output  1  valid with done; 1 = transaction aborted by timeout.
REQ-011 The block SHALL have port rdata  output  WIDTH  registered read data, valid with done.
REQ-012 The block SHALL have ports mem_addr, mem_wd  output  WIDTH; mem_we  output  1; mem_rd  input  WIDTH; mem_rdy  input  1  (shared memory side).

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, BUSY0, BUSY1, RESP.
REQ-014 In IDLE with only reqX high, the next state SHALL be BUSYX; with no request, the FSM SHALL stay in IDLE.
REQ-015 In IDLE with req0 and req1 both high, the FSM SHALL grant the port not served last, using a 1-bit last pointer; last=1 after reset, so port 0 wins the first tie.
REQ-016 gntX SHALL be 1 only while in BUSYX; gnt0 and gnt1 SHALL never be high together.
REQ-017 The mem_addr, mem_we and mem_wd outputs SHALL be combinational 2:1 selections of the granted port's signals; outside BUSY, mem_we SHALL be 0 and mem_addr/mem_wd SHALL be 0.
REQ-018 On entry to BUSYX, a cycle counter SHALL load 0 and then increment each BUSY cycle.
REQ-019 In BUSYX with mem_rdy=1, the FSM SHALL register rdata<=mem_rd, set err<=0, set last<=X, and go to RESP.
REQ-020 In BUSYX with mem_rdy=0 and counter==TIMEOUT-1, the FSM SHALL set err<=1, set rdata<=0, set last<=X, and go to RESP.
REQ-021 If mem_rdy=1 and the timeout condition occur in the same cycle, mem_rdy SHALL win and err SHALL be 0.
REQ-022 In RESP, doneX SHALL be 1 for exactly one cycle for the port just served, err and rdata SHALL hold, and the next state SHALL be IDLE.
REQ-023 Requests SHALL be ignored in BUSY and RESP; a request is sampled only in IDLE, so the minimum issue-to-issue time is 3 cycles for mem_rdy in the first BUSY cycle.
REQ-024 mem_rdy SHALL be ignored in IDLE and RESP.
REQ-025 A requester dropping req during BUSY SHALL NOT abort the transaction; it completes normally.
REQ-026 A write transaction SHALL complete identically to a read; rdata SHALL capture mem_rd regardless of we.

Reset
REQ-027 While reset=1 at a clock edge, the FSM SHALL enter IDLE with counter=0, last=1, gnt0=gnt1=0, done0=done1=0, err=0 and rdata=0.
REQ-028 Reset asserted in BUSY or RESP SHALL abandon the transaction without a done pulse; mem_we SHALL be 0 from the cycle after the reset edge.

Verification
REQ-029 After reset, req0=req1=1 in the same cycle, mem_rdy=1 one cycle after gnt -> gnt0 first, done0 pulse; the next tie -> gnt1.
REQ-030 req1=1, we1=1, addr1=0x40, wd1=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wd=0xDEADBEEF during BUSY1; done1=1, err=0 after mem_rdy.
REQ-031 req0=1, addr0=0x10, mem_rd=0x12345678, mem_rdy=1 on the 3rd BUSY cycle -> done0=1, rdata=0x12345678, err=0, exactly one pulse.
REQ-032 TIMEOUT=16, mem_rdy held at 0 -> exactly 16 BUSY cycles, then done=1, err=1, rdata=0; with mem_rdy=1 on cycle 16 instead -> err=0.
REQ-033 Reset asserted in the 2nd BUSY0 cycle -> IDLE next cycle, gnt0=0, no done0, mem_we=0.
REQ-034 mem_rdy=1 pulses while in IDLE, and req toggles during BUSY -> no state change in IDLE, no extra done, one done per granted transaction.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port memory arbiter: port 0 (ifetch) and port 1 (data) share one memory.
// Ties are broken toward the port not served last; a stalled access aborts after TIMEOUT cycles.
module mem_arb #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rd,
  input  logic             mem_rdy
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, RESP} state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_cnt;
  logic             r_last, r_port, r_err;
  logic [WIDTH-1:0] r_rdata;
  logic             w_busy, w_sel, w_timeout, w_finish;

  assign w_busy    = (r_state == BUSY0) || (r_state == BUSY1);
  assign w_sel     = (r_state == BUSY1);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));
  // mem_rdy in the timeout cycle still counts as a good completion
  assign w_finish  = w_busy && (mem_rdy || w_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1)  w_next = r_last ? BUSY0 : BUSY1;
        else if (req0)     w_next = BUSY0;
        else if (req1)     w_next = BUSY1;
      end
      BUSY0, BUSY1: if (w_finish) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_busy ? r_cnt + 8'd1 : 8'd0;
      if (w_finish) begin
        r_last  <= w_sel;
        r_port  <= w_sel;
        r_err   <= ~mem_rdy;
        r_rdata <= mem_rdy ? mem_rd : '0;
      end
    end
  end

  assign gnt0     = (r_state == BUSY0);
  assign gnt1     = (r_state == BUSY1);
  assign done0    = (r_state == RESP) && !r_port;
  assign done1    = (r_state == RESP) &&  r_port;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign mem_addr = !w_busy ? '0   : (w_sel ? addr1 : addr0);
  assign mem_wd   = !w_busy ? '0   : (w_sel ? wd1   : wd0);
  assign mem_we   = !w_busy ? 1'b0 : (w_sel ? we1   : we0);
endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: expected completions queued at issue, popped on done.
module tb_mem_arb;
  localparam int W  = 32;
  localparam int TO = 16;

  logic         clk = 1'b0, reset = 1'b1;
  logic         req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_rdy = 0;
  logic [W-1:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0, mem_rd = '0;
  logic         gnt0, gnt1, done0, done1, err, mem_we;
  logic [W-1:0] rdata, mem_addr, mem_wd;

  mem_arb #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1), .we0(we0), .we1(we1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   dn;
    logic         err;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // Issue one request pattern and observe it to completion (inputs change on negedges).
  // rdy_at: BUSY cycle (1-based) in which mem_rdy is raised, 0 = never.
  task automatic run_txn(input logic r0, input logic r1, input logic tog, input int rdy_at,
                         input logic [W-1:0] rd, output int busy_n, output logic [1:0] g,
                         output exp_t got, output int pulses, output logic mw,
                         output logic [W-1:0] ma, output logic [W-1:0] md);
    busy_n = 0; g = '0; got = '0; pulses = 0; mw = 0; ma = '0; md = '0;
    req0 = r0; req1 = r1; mem_rd = rd;
    for (int c = 0; c < 300 && pulses == 0; c++) begin
      @(negedge clk);
      if (gnt0 | gnt1) begin
        busy_n++;
        if (busy_n == 1) begin g = {gnt1, gnt0}; mw = mem_we; ma = mem_addr; md = mem_wd; end
        if (tog) begin req0 = ~req0; req1 = ~req1; end
        else     begin req0 = 0; req1 = 0; end
        mem_rdy = (busy_n == rdy_at);
      end else begin
        mem_rdy = 0;
      end
      if (done0 | done1) begin got = {done1, done0, err, rdata}; pulses = 1; end
    end
    req0 = 0; req1 = 0; mem_rdy = 0;
    repeat (3) begin @(negedge clk); if (done0 | done1) pulses++; end
  endtask

  int           bn, np;
  logic [1:0]   gg;
  exp_t         got, x;
  logic         mw;
  logic [W-1:0] ma, md;

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tot++;
    if ({gnt1, gnt0, done1, done0, err, mem_we} !== 6'b0)
      $display("FAIL reset_ctl got %b want 000000", {gnt1, gnt0, done1, done0, err, mem_we});
    else n_pass++;
    n_tot++;
    if (rdata !== '0) $display("FAIL reset_rdata got %h want 0", rdata); else n_pass++;
    n_tot++;
    if (mem_addr !== '0 || mem_wd !== '0)
      $display("FAIL reset_membus got %h/%h want 0/0", mem_addr, mem_wd);
    else n_pass++;
    reset = 0;
  endtask

  task automatic test_tie();
    sb.push_back({2'b01, 1'b0, 32'hA5A5_0001});
    run_txn(1, 1, 0, 2, 32'hA5A5_0001, bn, gg, got, np, mw, ma, md);
    n_tot++; if (gg !== 2'b01) $display("FAIL tie1_gnt got %b want 01", gg); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL tie1_resp got %h want %h", got, x); else n_pass++;
    n_tot++; if (np !== 1) $display("FAIL tie1_pulses got %0d want 1", np); else n_pass++;
    sb.push_back({2'b10, 1'b0, 32'hA5A5_0002});
    run_txn(1, 1, 0, 1, 32'hA5A5_0002, bn, gg, got, np, mw, ma, md);
    n_tot++; if (gg !== 2'b10) $display("FAIL tie2_gnt got %b want 10", gg); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL tie2_resp got %h want %h", got, x); else n_pass++;
  endtask

  task automatic test_write();
    we1 = 1; addr1 = 32'h40; wd1 = 32'hDEAD_BEEF;
    sb.push_back({2'b10, 1'b0, 32'hCAFE_0001});
    run_txn(0, 1, 0, 2, 32'hCAFE_0001, bn, gg, got, np, mw, ma, md);
    n_tot++;
    if ({mw, ma, md} !== {1'b1, 32'h40, 32'hDEAD_BEEF})
      $display("FAIL wr_bus got %b/%h/%h want 1/00000040/deadbeef", mw, ma, md);
    else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL wr_resp got %h want %h", got, x); else n_pass++;
    we1 = 0;
    n_tot++;
    if (mem_we !== 0 || mem_addr !== '0)
      $display("FAIL idle_bus got %b/%h want 0/0", mem_we, mem_addr);
    else n_pass++;
  endtask

  task automatic test_read();
    addr0 = 32'h10;
    sb.push_back({2'b01, 1'b0, 32'h1234_5678});
    run_txn(1, 0, 0, 3, 32'h1234_5678, bn, gg, got, np, mw, ma, md);
    n_tot++;
    if ({mw, ma} !== {1'b0, 32'h10}) $display("FAIL rd_bus got %b/%h want 0/00000010", mw, ma);
    else n_pass++;
    n_tot++; if (bn !== 3) $display("FAIL rd_busy got %0d want 3", bn); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL rd_resp got %h want %h", got, x); else n_pass++;
    n_tot++; if (np !== 1) $display("FAIL rd_pulses got %0d want 1", np); else n_pass++;
  endtask

  task automatic test_timeout();
    sb.push_back({2'b01, 1'b1, 32'h0});
    run_txn(1, 0, 0, 0, 32'hFFFF_FFFF, bn, gg, got, np, mw, ma, md);
    n_tot++; if (bn !== TO) $display("FAIL to_busy got %0d want %0d", bn, TO); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL to_resp got %h want %h", got, x); else n_pass++;
    sb.push_back({2'b01, 1'b0, 32'h5555_AAAA});
    run_txn(1, 0, 0, TO, 32'h5555_AAAA, bn, gg, got, np, mw, ma, md);
    n_tot++; if (bn !== TO) $display("FAIL race_busy got %0d want %0d", bn, TO); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL race_resp got %h want %h", got, x); else n_pass++;
  endtask

  task automatic test_idle_noise();
    logic bad = 0;
    for (int c = 0; c < 6; c++) begin
      mem_rdy = c[0];
      @(negedge clk);
      if (gnt0 | gnt1 | done0 | done1) bad = 1;
    end
    mem_rdy = 0;
    n_tot++; if (bad !== 0) $display("FAIL idle_rdy got %b want 0", bad); else n_pass++;
    sb.push_back({2'b01, 1'b0, 32'h0BAD_F00D});
    run_txn(1, 0, 1, 4, 32'h0BAD_F00D, bn, gg, got, np, mw, ma, md);
    n_tot++; if (bn !== 4) $display("FAIL tog_busy got %0d want 4", bn); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL tog_resp got %h want %h", got, x); else n_pass++;
    n_tot++; if (np !== 1) $display("FAIL tog_pulses got %0d want 1", np); else n_pass++;
  endtask

  task automatic test_reset_busy();
    logic seen = 0;
    logic bad = 0;
    req0 = 1; we0 = 1; addr0 = 32'h20;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = gnt0;
    end
    req0 = 0;
    n_tot++; if (seen !== 1) $display("FAIL rb_gnt got %b want 1", seen); else n_pass++;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    n_tot++;
    if ({gnt0, done0, mem_we} !== 3'b000)
      $display("FAIL rb_abort got %b want 000", {gnt0, done0, mem_we});
    else n_pass++;
    reset = 0; we0 = 0;
    repeat (4) begin @(negedge clk); if (done0 | done1 | gnt0 | gnt1) bad = 1; end
    n_tot++; if (bad !== 0) $display("FAIL rb_quiet got %b want 0", bad); else n_pass++;
  endtask

  task automatic test_tie_after_reset();
    sb.push_back({2'b01, 1'b0, 32'h7777_0003});
    run_txn(1, 1, 0, 1, 32'h7777_0003, bn, gg, got, np, mw, ma, md);
    n_tot++; if (gg !== 2'b01) $display("FAIL tie3_gnt got %b want 01", gg); else n_pass++;
    x = sb.pop_front();
    n_tot++; if (got !== x) $display("FAIL tie3_resp got %h want %h", got, x); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write();
    test_read();
    test_timeout();
    test_idle_noise();
    test_reset_busy();
    test_tie_after_reset();
    n_tot++;
    if (sb.size() != 0) $display("FAIL sb_empty got %0d want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
